// File: rtl/celda_media_serial.sv
// Bit-serial MSB-first divisible-by-3 cell: scans WIDTH bits carrying a mod-3 residue, drives f_mid.
// Optional macro CELDA_MEDIA_ABORT_EN adds an abort input that cancels a running scan.
module celda_media_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CELDA_MEDIA_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             busy,
  output logic             f_mid,
  output logic             f_mid_valid
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [1:0]       residue_reg, residue_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             f_mid_reg, f_mid_next;
  logic             valid_reg, valid_next;
  logic             abort_req;

`ifdef CELDA_MEDIA_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // (2*r + b) mod 3 over the legal residues 0..2; code 3 never occurs.
  function automatic logic [1:0] residue_step(input logic [1:0] r, input logic b);
    case ({r, b})
      3'b000:  residue_step = 2'd0;
      3'b001:  residue_step = 2'd1;
      3'b010:  residue_step = 2'd2;
      3'b011:  residue_step = 2'd0;
      3'b100:  residue_step = 2'd1;
      3'b101:  residue_step = 2'd2;
      default: residue_step = 2'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      residue_reg <= '0;
      count_reg   <= '0;
      f_mid_reg   <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      residue_reg <= residue_next;
      count_reg   <= count_next;
      f_mid_reg   <= f_mid_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    residue_next = residue_reg;
    count_next   = count_reg;
    f_mid_next   = f_mid_reg;
    valid_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          shift_next   = data_in;
          residue_next = 2'd0;
          count_next   = CW'(WIDTH);
          state_next   = SCAN;
        end
      end
      SCAN: begin
        // Abort outranks completion: f_mid keeps its last published value.
        if (abort_req) begin
          count_next = '0;
          state_next = IDLE;
        end else begin
          residue_next = residue_step(residue_reg, shift_reg[WIDTH-1]);
          shift_next   = {shift_reg[WIDTH-2:0], 1'b0};
          count_next   = count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            f_mid_next = (residue_next == 2'd0);
            valid_next = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign ready       = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign f_mid       = f_mid_reg;
  assign f_mid_valid = valid_reg;

endmodule

// File: tb/tb_celda_media_serial.sv
// Randomized self-checking bench for celda_media_serial against an arithmetic mod-3 model.
module tb_celda_media_serial;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data_in;
  logic         ready, busy, f_mid, f_mid_valid;
`ifdef CELDA_MEDIA_ABORT_EN
  logic         abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  celda_media_serial #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef CELDA_MEDIA_ABORT_EN
    .abort      (abort),
`endif
    .start      (start),
    .data_in    (data_in),
    .ready      (ready),
    .busy       (busy),
    .f_mid      (f_mid),
    .f_mid_valid(f_mid_valid)
  );

  always #5 clk = ~clk;

  function automatic logic model_div3(input int v);
    return (v % 3) == 0;
  endfunction

  // One active edge; outputs are then sampled and inputs driven 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue start with v and run until the valid pulse (bounded); the caller checks the results.
  task automatic do_scan(input logic [W-1:0] v, output logic got_f, output int cycles,
                         output logic hold_ok, output logic ready_done);
    logic f_prev;
    f_prev     = f_mid;
    hold_ok    = 1'b1;
    cycles     = -1;
    got_f      = 1'b0;
    ready_done = 1'b0;
    start   = 1'b1;
    data_in = v;
    step();
    start = 1'b0;
    for (int k = 1; k <= W + 4; k++) begin
      data_in = W'($urandom);
      step();
      if (f_mid_valid) begin
        cycles     = k;
        got_f      = f_mid;
        ready_done = ready;
        break;
      end
      if (f_mid !== f_prev || ready !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; data_in = 8'h00;
    step(); step();
    checks++;
    if ({ready, busy, f_mid, f_mid_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state: got ready/busy/f_mid/valid=%b expected 1000", {ready, busy, f_mid, f_mid_valid});
    end
    rst_n = 1'b1; start = 1'b0;
    step();
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_ignored: got ready=%b busy=%b expected ready=1 busy=0", ready, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_zero();
    logic f, hold, rdy; int cyc;
    do_scan(8'h00, f, cyc, hold, rdy);
    checks++;
    if (cyc !== W || f !== 1'b1 || rdy !== 1'b1 || hold !== 1'b1) begin
      errors++;
      $display("FAIL zero_scan: got cycles=%0d f_mid=%b ready=%b hold=%b expected %0d 1 1 1", cyc, f, rdy, hold, W);
    end
    step();
    checks++;
    if (f_mid_valid !== 1'b0 || f_mid !== 1'b1) begin
      errors++;
      $display("FAIL valid_one_cycle: got valid=%b f_mid=%b expected valid=0 f_mid=1", f_mid_valid, f_mid);
    end
    $display("scan 0x00: cycles=%0d f_mid=%b", cyc, f);
  endtask

  task automatic test_back_to_back();
    logic f, hold, rdy; int cyc;
    do_scan(8'h07, f, cyc, hold, rdy);
    checks++;
    if (cyc !== W || f !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got cycles=%0d f_mid=%b expected %0d 0", cyc, f, W);
    end
    do_scan(8'hFF, f, cyc, hold, rdy);
    checks++;
    if (cyc !== W || f !== 1'b1 || hold !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: got cycles=%0d f_mid=%b hold=%b expected %0d 1 1", cyc, f, hold, W);
    end
    $display("back-to-back 0x07,0xFF: second cycles=%0d f_mid=%b", cyc, f);
  endtask

  task automatic test_start_ignored();
    int pulses, at; logic f;
    pulses = 0; at = -1; f = 1'b0;
    start = 1'b1; data_in = 8'h03;
    step();
    start = 1'b0;
    for (int k = 1; k <= 2 * W + 2; k++) begin
      start   = (k == 3);
      data_in = (k == 3) ? 8'h01 : W'($urandom);
      step();
      if (f_mid_valid) begin
        pulses++;
        if (at < 0) begin at = k; f = f_mid; end
      end
    end
    start = 1'b0;
    checks++;
    if (pulses !== 1 || at !== W || f !== 1'b1) begin
      errors++;
      $display("FAIL start_during_scan: got pulses=%0d at=%0d f_mid=%b expected 1 %0d 1", pulses, at, f, W);
    end
    $display("start ignored during scan: pulses=%0d at edge %0d", pulses, at);
  endtask

  task automatic test_reset_mid_scan();
    int pulses; logic f, hold, rdy; int cyc;
    pulses = 0;
    start = 1'b1; data_in = 8'h06;
    step();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || f_mid !== 1'b0 || f_mid_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_scan: got ready=%b busy=%b f_mid=%b valid=%b expected 1 0 0 0", ready, busy, f_mid, f_mid_valid);
    end
    for (int k = 0; k < W + 2; k++) begin
      step();
      if (f_mid_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_discard: got pulses=%0d expected 0", pulses);
    end
    do_scan(8'h05, f, cyc, hold, rdy);
    checks++;
    if (cyc !== W || f !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_scan: got cycles=%0d f_mid=%b expected %0d 0", cyc, f, W);
    end
    $display("reset mid-scan then 0x05: f_mid=%b", f);
  endtask

  task automatic test_random();
    logic f, hold, rdy, exp_f; int cyc; logic [W-1:0] v;
    for (int n = 0; n < 40; n++) begin
      v = W'($urandom);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        start = 1'b0; data_in = W'($urandom);
        step();
      end
      exp_f = model_div3(int'(v));
      do_scan(v, f, cyc, hold, rdy);
      checks++;
      if (cyc !== W || f !== exp_f || hold !== 1'b1 || rdy !== 1'b1) begin
        errors++;
        $display("FAIL random_scan: v=%0d got cycles=%0d f_mid=%b hold=%b ready=%b expected %0d %b 1 1",
                 v, cyc, f, hold, rdy, W, exp_f);
      end
      $display("random v=%0d f_mid=%b expected=%b", v, f, exp_f);
    end
  endtask

  task automatic test_sweep();
    logic f, hold, rdy; int cyc, ones;
    ones = 0;
    for (int v = 0; v < 256; v++) begin
      do_scan(W'(v), f, cyc, hold, rdy);
      if (f === 1'b1) ones++;
      checks++;
      if (cyc !== W || f !== model_div3(v) || hold !== 1'b1) begin
        errors++;
        $display("FAIL sweep: v=%0d got cycles=%0d f_mid=%b hold=%b expected %0d %b 1", v, cyc, f, hold, W, model_div3(v));
      end
    end
    checks++;
    if (ones !== 86) begin
      errors++;
      $display("FAIL sweep_ones: got %0d expected 86", ones);
    end
    $display("sweep 0..255: ones=%0d", ones);
  endtask

`ifdef CELDA_MEDIA_ABORT_EN
  task automatic test_abort();
    logic f, hold, rdy; int cyc, pulses, at;
    pulses = 0; at = -1;
    do_scan(8'h03, f, cyc, hold, rdy);
    start = 1'b1; data_in = 8'h09;
    step();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      abort = (k == 5);
      step();
      if (f_mid_valid) pulses++;
    end
    abort = 1'b0;
    checks++;
    if (ready !== 1'b1 || f_mid !== 1'b1 || f_mid_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_scan: got ready=%b f_mid=%b valid=%b expected 1 1 0", ready, f_mid, f_mid_valid);
    end
    for (int k = 0; k < W + 2; k++) begin
      step();
      if (f_mid_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL abort_no_pulse: got pulses=%0d expected 0", pulses);
    end
    abort = 1'b1;
    step();
    checks++;
    if (ready !== 1'b1 || f_mid !== 1'b1 || f_mid_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got ready=%b f_mid=%b valid=%b expected 1 1 0", ready, f_mid, f_mid_valid);
    end
    start = 1'b1; data_in = 8'h04;
    step();
    start = 1'b0; abort = 1'b0;
    for (int k = 1; k <= W + 4; k++) begin
      step();
      if (f_mid_valid) begin at = k; f = f_mid; break; end
    end
    checks++;
    if (at !== W || f !== 1'b0) begin
      errors++;
      $display("FAIL abort_with_start: got at=%0d f_mid=%b expected %0d 0", at, f, W);
    end
    $display("abort tests done");
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; data_in = '0;
    test_reset();
    test_zero();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_scan();
    test_random();
    test_sweep();
`ifdef CELDA_MEDIA_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/celda_media_serial.md
Name: celda_media_serial

Overview:
- Bit-serial, left-to-right (MSB-first) iterative cell engine. Sits directly upstream of the final cell and produces the `f_mid` signal that the final cell consumes.
- Scans a WIDTH-bit operand one bit per clock and carries a mod-3 residue from cell to cell.
- Asserts `f_mid`=1 when the operand is divisible by 3, else 0.
- Start/ready/valid handshake gives the block real sequencing. `f_mid` is held stable between results so the final cell sees a steady level.

Parameters:
- WIDTH, 8, operand width in bits (≥2); number of scan cycles.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset (sampled on rising edge of clk).
- start  input  1  request to begin a scan; honoured only when ready=1.
- data_in  input  WIDTH  operand; sampled only on the accepting edge.
- ready  output  1  1 when idle and able to accept start.
- busy  output  1  1 while scanning (inverse of ready).
- f_mid  output  1  divisibility result of the last completed scan; held until the next completion.
- f_mid_valid  output  1  one-cycle pulse marking a new f_mid.

Behaviour:
- States: IDLE, SCAN.
- Reset (rst_n=0 at an edge), from any state including mid-scan:
  - state=IDLE, ready=1, busy=0
  - f_mid=0, f_mid_valid=0
  - residue=0, count=0, shift register=0
  - An in-progress scan is discarded with no valid pulse.
- IDLE:
  - On an edge with start=1: load shift register with data_in, residue=0, count=WIDTH, go to SCAN.
  - ready=0 and busy=1 from the next cycle.
  - start=0 keeps IDLE.
- SCAN, on each edge:
  - bit = shift register MSB; residue ← (2·residue + bit) mod 3.
  - Shift register shifts left, filling 0; count decrements.
  - Residue is 2 bits, encoded only as values 0,1,2; value 3 is never reachable.
- Completion, on the edge consuming the last bit (count=1→0):
  - f_mid ← (new residue == 0).
  - f_mid_valid ← 1 for exactly one cycle.
  - state ← IDLE, ready ← 1.
- Latency:
  - Start accepted at edge E0; f_mid/f_mid_valid are visible after edge E0+WIDTH.
  - Throughput is one result per WIDTH cycles.
- start=1 during SCAN is ignored; it is neither queued nor restarts the scan.
- Back-to-back:
  - start=1 in the cycle where f_mid_valid=1 (ready=1) is accepted.
  - The next result arrives WIDTH edges later.
  - f_mid holds the previous result meanwhile.
- data_in changes after the accepting edge do not affect the running scan.
- start and rst_n=0 on the same edge: reset wins; the block stays IDLE.
- f_mid_valid is 0 in every cycle except the completion cycle.

Optional Feature:
- Macro: CELDA_MEDIA_ABORT_EN
- Defined:
  - Adds input port `abort` (1 bit).
  - abort=1 on an edge in SCAN → IDLE, ready=1, no f_mid_valid pulse, f_mid unchanged.
  - abort on the completion edge takes priority over completion: no pulse, f_mid unchanged.
  - abort in IDLE has no effect.
  - abort and start in IDLE on the same edge: start is accepted.
- Undefined: no `abort` port; every accepted scan runs to completion unless reset.

Test Plan:
- WIDTH=8; reset, then start with data_in=8'h00 → f_mid_valid pulses 8 edges after accept, f_mid=1; ready returns 1 in the same cycle.
- data_in=8'h07 (7 mod 3=1) → f_mid=0; then data_in=8'hFF (255) back-to-back in the valid cycle → second pulse 8 edges later with f_mid=1; f_mid stays 0 in between.
- Start with 8'h03, then pulse start with 8'h01 at scan edge 3 → ignored; single pulse at edge 8 with f_mid=1; exactly one valid pulse observed.
- Start 8'h06, drive rst_n=0 at scan edge 4 → next cycle ready=1, f_mid=0, no valid pulse; a new scan of 8'h05 then yields f_mid=0.
- Sweep all 256 operands back-to-back → each f_mid equals (value%3==0); 86 ones counted.
- With CELDA_MEDIA_ABORT_EN: start 8'h09, abort at scan edge 5 → IDLE next cycle, no pulse, f_mid keeps its prior value; abort asserted in IDLE → no change.
